// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - opcode/handshake inputs and datapath control bundle for the multicycle sequencer
// master = sequencer driving the controls, slave = datapath side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] MemtoReg;
  logic [1:0] RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] state_o;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state_o,
           instr_done, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state_o,
           instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control sequencer (fetch/decode/execute/memory/writeback)
// Outputs decode the state register; only the handshake/decode pulses also look at mem_ready/opcode.
module multicycle_control (
  input logic             clk,
  input logic             reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_JUMP   = 4'd10,
    S_JAL    = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  if (bus.mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_LW, OP_LB, OP_SW: r_state <= S_MEMADR;
            OP_ADDI:             r_state <= S_ADDIEX;
            OP_RTYPE:            r_state <= S_EXEC;
            OP_BEQ:              r_state <= S_BRANCH;
            OP_J:                r_state <= S_JUMP;
            OP_JAL:              r_state <= S_JAL;
            default:             r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: r_state <= (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (bus.mem_ready) r_state <= S_MEMWB;
        S_MEMWR:  if (bus.mem_ready) r_state <= S_FETCH;
        S_EXEC:   r_state <= S_RWB;
        S_ADDIEX: r_state <= S_ADDIWB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 2'b00;
    bus.RegDst      = 2'b00;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    bus.state_o     = 4'd0;
    bus.instr_done  = 1'b0;
    bus.illegal_op  = 1'b0;
    // Reset blanks everything so an aborted MEMWR cannot leak a write strobe.
    if (!reset) begin
      bus.state_o = r_state;
      case (r_state)
        S_FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = 2'b01;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        S_DECODE: begin
          bus.ALUSrcB = 2'b11;
          case (bus.opcode)
            OP_LW, OP_LB, OP_SW, OP_ADDI, OP_RTYPE, OP_BEQ, OP_J, OP_JAL: ;
            default: begin
              bus.illegal_op = 1'b1;
              bus.instr_done = 1'b1;
            end
          endcase
        end
        S_MEMADR, S_ADDIEX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          bus.IorD    = 1'b1;
          bus.MemRead = 1'b1;
        end
        S_MEMWB: begin
          bus.MemtoReg   = 2'b01;
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_MEMWR: begin
          bus.IorD       = 1'b1;
          bus.MemWrite   = 1'b1;
          bus.instr_done = bus.mem_ready;
        end
        S_EXEC: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = 2'b10;
        end
        S_RWB: begin
          bus.RegDst     = 2'b01;
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_BRANCH: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUOp       = 2'b01;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = 2'b01;
          bus.instr_done  = 1'b1;
        end
        S_ADDIWB: begin
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_JUMP: begin
          bus.PCWrite    = 1'b1;
          bus.PCSource   = 2'b10;
          bus.instr_done = 1'b1;
        end
        S_JAL: begin
          bus.PCWrite    = 1'b1;
          bus.PCSource   = 2'b10;
          bus.RegDst     = 2'b10;
          bus.MemtoReg   = 2'b10;
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed-vector bench for multicycle_control with per-cycle expected control words
// Each instruction expands into its per-cycle control words; one compare process checks every cycle.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if ifc ();
  multicycle_control dut (.clk(clk), .reset(reset), .bus(ifc));

  typedef struct packed {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [23:0] exp;
  } vec_t;

  vec_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic        chk_en = 1'b0;
  logic [23:0] exp_cur = '0;
  int          step = 0;
  int n_done = 0, n_ill = 0, n_mw = 0, n_rw = 0;

  wire [23:0] dut_word = {ifc.PCWrite, ifc.PCWriteCond, ifc.IorD, ifc.MemRead,
                          ifc.MemWrite, ifc.IRWrite, ifc.MemtoReg, ifc.RegDst,
                          ifc.RegWrite, ifc.ALUSrcA, ifc.ALUSrcB, ifc.ALUOp,
                          ifc.PCSource, ifc.state_o, ifc.instr_done, ifc.illegal_op};

  function automatic logic [23:0] ctl(
      input logic [3:0] st, input logic pcw, input logic pcwc, input logic iord,
      input logic mr, input logic mw, input logic irw, input logic [1:0] m2r,
      input logic [1:0] rdst, input logic rw, input logic asa, input logic [1:0] asb,
      input logic [1:0] aop, input logic [1:0] pcs, input logic done, input logic ill);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, pcs, st, done, ill};
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic push(input logic r, input logic [5:0] op, input logic rdy, input logic [23:0] e);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.exp = e;
    q.push_back(v);
  endtask

  task automatic add_reset(input int n);
    for (int k = 0; k < n; k++) push(1'b1, 6'h15, 1'b0, 24'h0);
  endtask

  // Expands one instruction: fst fetch stalls, mst memory stalls, idle = mem_ready driven where it must be ignored.
  task automatic add_instr(input logic [5:0] op, input int fst, input int mst, input logic idle);
    logic [5:0] junk;
    junk = op ^ 6'h2A;
    for (int k = 0; k < fst; k++) push(1'b0, junk, 1'b0, ctl(0,0,0,0,1,0,0,0,0,0,0,1,0,0,0,0));
    push(1'b0, junk, 1'b1, ctl(0,1,0,0,1,0,1,0,0,0,0,1,0,0,0,0));
    case (op)
      6'b100011, 6'b100000: begin
        push(1'b0, op, idle, ctl(1,0,0,0,0,0,0,0,0,0,0,3,0,0,0,0));
        push(1'b0, op, idle, ctl(2,0,0,0,0,0,0,0,0,0,1,2,0,0,0,0));
        for (int k = 0; k < mst; k++) push(1'b0, op, 1'b0, ctl(3,0,0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        push(1'b0, op, 1'b1, ctl(3,0,0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        push(1'b0, op, idle, ctl(4,0,0,0,0,0,0,1,0,1,0,0,0,0,1,0));
      end
      6'b101011: begin
        push(1'b0, op, idle, ctl(1,0,0,0,0,0,0,0,0,0,0,3,0,0,0,0));
        push(1'b0, op, idle, ctl(2,0,0,0,0,0,0,0,0,0,1,2,0,0,0,0));
        for (int k = 0; k < mst; k++) push(1'b0, op, 1'b0, ctl(5,0,0,1,0,1,0,0,0,0,0,0,0,0,0,0));
        push(1'b0, op, 1'b1, ctl(5,0,0,1,0,1,0,0,0,0,0,0,0,0,1,0));
      end
      6'b000000: begin
        push(1'b0, op, idle, ctl(1,0,0,0,0,0,0,0,0,0,0,3,0,0,0,0));
        push(1'b0, op, idle, ctl(6,0,0,0,0,0,0,0,0,0,1,0,2,0,0,0));
        push(1'b0, op, idle, ctl(7,0,0,0,0,0,0,0,1,1,0,0,0,0,1,0));
      end
      6'b000100: begin
        push(1'b0, op, idle, ctl(1,0,0,0,0,0,0,0,0,0,0,3,0,0,0,0));
        push(1'b0, op, idle, ctl(8,0,1,0,0,0,0,0,0,0,1,0,1,1,1,0));
      end
      6'b001000: begin
        push(1'b0, op, idle, ctl(1,0,0,0,0,0,0,0,0,0,0,3,0,0,0,0));
        push(1'b0, op, idle, ctl(9,0,0,0,0,0,0,0,0,0,1,2,0,0,0,0));
        push(1'b0, op, idle, ctl(12,0,0,0,0,0,0,0,0,1,0,0,0,0,1,0));
      end
      6'b000010: begin
        push(1'b0, op, idle, ctl(1,0,0,0,0,0,0,0,0,0,0,3,0,0,0,0));
        push(1'b0, op, idle, ctl(10,1,0,0,0,0,0,0,0,0,0,0,0,2,1,0));
      end
      6'b000011: begin
        push(1'b0, op, idle, ctl(1,0,0,0,0,0,0,0,0,0,0,3,0,0,0,0));
        push(1'b0, op, idle, ctl(11,1,0,0,0,0,0,2,2,1,0,0,0,2,1,0));
      end
      default: push(1'b0, op, idle, ctl(1,0,0,0,0,0,0,0,0,0,0,3,0,0,1,1));
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (dut_word !== exp_cur) begin
        n_fail++;
        $display("FAIL cycle_word step=%0d got=%h exp=%h", step, dut_word, exp_cur);
      end
      n_done += int'(ifc.instr_done);
      n_ill  += int'(ifc.illegal_op);
      n_mw   += int'(ifc.MemWrite);
      n_rw   += int'(ifc.RegWrite);
    end
  end

  initial begin
    int s0;
    ifc.opcode = 6'h0;
    ifc.mem_ready = 1'b0;

    add_reset(3);
    s0 = q.size(); add_instr(6'b100011, 0, 0, 1'b1); check("lat_lw", q.size() - s0, 5);
    s0 = q.size(); add_instr(6'b101011, 1, 2, 1'b0); check("lat_sw_stalled", q.size() - s0, 7);
    s0 = q.size();
    add_instr(6'b000000, 0, 0, 1'b0);
    add_instr(6'b000100, 0, 0, 1'b0);
    add_instr(6'b000011, 0, 0, 1'b1);
    check("lat_r_beq_jal", q.size() - s0, 10);
    s0 = q.size(); add_instr(6'b111111, 0, 0, 1'b1); check("lat_illegal", q.size() - s0, 2);
    s0 = q.size(); add_instr(6'b001000, 0, 0, 1'b0); check("lat_addi", q.size() - s0, 4);
    s0 = q.size(); add_instr(6'b000010, 0, 0, 1'b1); check("lat_j", q.size() - s0, 3);
    add_instr(6'b100000, 2, 1, 1'b0);
    add_instr(6'b100011, 0, 2, 1'b1);
    void'(q.pop_back());
    void'(q.pop_back());
    add_reset(2);
    add_instr(6'b100011, 0, 0, 1'b0);

    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      reset = q[i].rst;
      ifc.opcode = q[i].op;
      ifc.mem_ready = q[i].rdy;
      exp_cur = q[i].exp;
      step = i;
      chk_en = 1'b1;
      if (i == 3) begin
        @(negedge clk);
        #1;
        check("first_fetch_state", int'(ifc.state_o), 0);
        check("first_fetch_memread", int'(ifc.MemRead), 1);
        check("first_fetch_alusrcb", int'(ifc.ALUSrcB), 1);
      end
    end
    @(posedge clk);
    #1;
    chk_en = 1'b0;

    check("instr_done_pulses", n_done, 10);
    check("illegal_op_pulses", n_ill, 1);
    check("memwrite_cycles", n_mw, 3);
    check("regwrite_cycles", n_rw, 6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
